// File: rtl/safe_pkg.sv
// rtl/safe_pkg.sv - state encodings and default parameters for the safe lockout controller
package safe_pkg;

  typedef enum logic [2:0] {
    S_OPEN    = 3'b000,
    S_SETPW   = 3'b001,
    S_ARMED   = 3'b010,
    S_TRY     = 3'b011,
    S_EVAL    = 3'b100,
    S_UNLOCK  = 3'b101,
    S_LOCKOUT = 3'b110
  } state_t;

  localparam int CODE_W_DEF         = 4;
  localparam int MAX_FAILS_DEF      = 3;
  localparam int LOCKOUT_CYCLES_DEF = 50_000_000;

endpackage

// File: rtl/lockout_timer.sv
// rtl/lockout_timer.sv - loadable down-counter; done is high whenever the count is zero
module lockout_timer #(
  parameter int CYCLES = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic dec,
  output logic done
);

  localparam int TW = $clog2(CYCLES + 1);

  logic [TW-1:0] count_q, count_d;

  // Loading CYCLES-1 makes the zero cycle the last of CYCLES counted cycles.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = TW'(CYCLES - 1);
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done = (count_q == '0);

endmodule

// File: rtl/safe_lockout_ctrl.sv
// rtl/safe_lockout_ctrl.sv - safe unlock sequencer with password/attempt registers and failed-attempt lockout
module safe_lockout_ctrl
  import safe_pkg::*;
#(
  parameter int CODE_W         = CODE_W_DEF,
  parameter int MAX_FAILS      = MAX_FAILS_DEF,
  parameter int LOCKOUT_CYCLES = LOCKOUT_CYCLES_DEF
) (
  input  logic                           clk,
  input  logic                           RESET,
  input  logic                           ENTER,
  input  logic [CODE_W-1:0]              CODE,
  output logic                           LOCKED,
  output logic                           ALARM,
  output logic [$clog2(MAX_FAILS+1)-1:0] fail_count,
  output logic [2:0]                     present_state_bits
);

  localparam int FW = $clog2(MAX_FAILS + 1);

  state_t            state_q, state_d;
  logic [CODE_W-1:0] pw_q, pw_d;
  logic [CODE_W-1:0] at_q, at_d;
  logic [FW-1:0]     fail_q, fail_d;
  logic              tmr_load;
  logic              tmr_done;

  always_comb begin
    state_d  = state_q;
    pw_d     = pw_q;
    at_d     = at_q;
    fail_d   = fail_q;
    tmr_load = 1'b0;
    case (state_q)
      S_OPEN:   if (ENTER) state_d = S_SETPW;
      S_SETPW: begin
        pw_d = CODE;
        if (!ENTER) state_d = S_ARMED;
      end
      S_ARMED:  if (ENTER) state_d = S_TRY;
      S_TRY: begin
        at_d = CODE;
        if (!ENTER) state_d = S_EVAL;
      end
      S_EVAL: begin
        if (at_q == pw_q) begin
          state_d = S_UNLOCK;
          fail_d  = '0;
        end else if ((int'(fail_q) + 1) < MAX_FAILS) begin
          state_d = S_ARMED;
          fail_d  = fail_q + 1'b1;
        end else begin
          state_d  = S_LOCKOUT;
          fail_d   = FW'(MAX_FAILS);
          tmr_load = 1'b1;
        end
      end
      S_UNLOCK: if (ENTER) state_d = S_SETPW;
      S_LOCKOUT: begin
        // The password survives lockout; only the failure history is cleared.
        if (tmr_done) begin
          state_d = S_ARMED;
          fail_d  = '0;
        end
      end
      default:  state_d = S_OPEN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      state_q <= S_OPEN;
      pw_q    <= '0;
      at_q    <= '0;
      fail_q  <= '0;
    end else begin
      state_q <= state_d;
      pw_q    <= pw_d;
      at_q    <= at_d;
      fail_q  <= fail_d;
    end
  end

  lockout_timer #(
    .CYCLES(LOCKOUT_CYCLES)
  ) u_timer (
    .clk  (clk),
    .rst  (RESET),
    .load (tmr_load),
    .dec  (state_q == S_LOCKOUT),
    .done (tmr_done)
  );

  assign LOCKED             = (state_q == S_ARMED) || (state_q == S_TRY) ||
                              (state_q == S_EVAL)  || (state_q == S_LOCKOUT);
  assign ALARM              = (state_q == S_LOCKOUT);
  assign fail_count         = fail_q;
  assign present_state_bits = state_q;

endmodule

// File: tb/tb_safe_lockout_ctrl.sv
// tb/tb_safe_lockout_ctrl.sv - scoreboard bench: press-level reference model vs resting-state events of the DUT
module tb_safe_lockout_ctrl;

  localparam int CW = 4;
  localparam int MF = 3;
  localparam int L  = 8;

  localparam int M_OPEN   = 0;
  localparam int M_ARMED  = 1;
  localparam int M_UNLOCK = 2;
  localparam int M_LOCK   = 3;

  typedef struct {
    int         cyc;
    logic [2:0] st;
    logic       lk;
    logic       al;
    logic [1:0] fc;
  } exp_t;

  logic          clk;
  logic          RESET;
  logic          ENTER;
  logic [CW-1:0] CODE;
  logic          LOCKED;
  logic          ALARM;
  logic [1:0]    fail_count;
  logic [2:0]    present_state_bits;

  safe_lockout_ctrl #(
    .CODE_W(CW),
    .MAX_FAILS(MF),
    .LOCKOUT_CYCLES(L)
  ) dut (
    .clk(clk),
    .RESET(RESET),
    .ENTER(ENTER),
    .CODE(CODE),
    .LOCKED(LOCKED),
    .ALARM(ALARM),
    .fail_count(fail_count),
    .present_state_bits(present_state_bits)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   cyc = 0;
  logic rst_seen = 1'b0;
  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_seen <= RESET;
  end

  exp_t      q[$];
  int        checks = 0;
  int        failures = 0;
  int        mode = M_OPEN;
  int        fails = 0;
  int        lock_end = 0;
  logic [CW-1:0] pw = '0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int c, input logic [2:0] st, input logic lk, input logic al, input int fc);
    exp_t e;
    e.cyc = c; e.st = st; e.lk = lk; e.al = al; e.fc = 2'(fc);
    q.push_back(e);
  endtask

  // Monitor: every entry into a resting state (or a sampled reset) must match the next expectation.
  initial begin
    logic [2:0] prev_st;
    logic [2:0] cur;
    logic       resting;
    exp_t       e;
    prev_st = 3'b111;
    forever begin
      @(negedge clk);
      cur     = present_state_bits;
      resting = (cur == 3'b000) || (cur == 3'b010) || (cur == 3'b101) || (cur == 3'b110);
      if (rst_seen || (resting && (cur != prev_st))) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_event: got state %0d expected no event (cycle %0d)", cur, cyc);
        end else begin
          e = q.pop_front();
          chk("event_cycle", cyc, e.cyc);
          chk("state_bits", int'(cur), int'(e.st));
          chk("locked", int'(LOCKED), int'(e.lk));
          chk("alarm", int'(ALARM), int'(e.al));
          chk("fail_count", int'(fail_count), int'(e.fc));
        end
      end
      prev_st = cur;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    while ((q.size() > 0) && (q[$].cyc >= cyc)) void'(q.pop_back());
    push(cyc, 3'b000, 1'b0, 1'b0, 0);
    mode  = M_OPEN;
    fails = 0;
    pw    = '0;
  endtask

  // One-cycle press; CODE is only meaningful on the release edge.
  task automatic press(input logic [CW-1:0] code);
    int e;
    ENTER = 1'b1;
    CODE  = CW'($urandom);
    tick();
    e     = cyc;
    ENTER = 1'b0;
    CODE  = code;
    tick();
    CODE  = CW'($urandom);
    if ((mode == M_LOCK) && (e > lock_end)) mode = M_ARMED;
    case (mode)
      M_OPEN, M_UNLOCK: begin
        pw   = code;
        mode = M_ARMED;
        push(e + 1, 3'b010, 1'b1, 1'b0, fails);
      end
      M_ARMED: begin
        if (code == pw) begin
          fails = 0;
          mode  = M_UNLOCK;
          push(e + 2, 3'b101, 1'b0, 1'b0, 0);
        end else if (fails + 1 < MF) begin
          fails++;
          push(e + 2, 3'b010, 1'b1, 1'b0, fails);
        end else begin
          push(e + 2, 3'b110, 1'b1, 1'b1, MF);
          push(e + 2 + L, 3'b010, 1'b1, 1'b0, 0);
          fails    = 0;
          mode     = M_LOCK;
          lock_end = e + 2 + L;
        end
      end
      default: ;
    endcase
    idle(1 + int'($urandom % 3));
  endtask

  initial begin
    RESET = 1'b0;
    ENTER = 1'b0;
    CODE  = '0;
    do_reset();
    idle(2);

    press(4'hA);
    press(4'hA);
    press(4'hA);
    press(4'h3);
    press(4'h5);
    press(4'hA);

    press(4'h1);
    press(4'h2);
    press(4'h3);
    press(4'hA);
    press(4'hA);
    while (cyc <= lock_end) tick();
    press(4'hA);

    press(4'h6);
    press(4'hA);
    press(4'h6);

    press(4'hA);
    press(4'h1);
    press(4'h2);
    press(4'h3);
    while (cyc < lock_end - L + 4) tick();
    do_reset();
    idle(2);
    press(4'h9);
    press(4'h4);
    press(4'h9);

    for (int i = 0; i < 80; i++) begin
      int r;
      r = int'($urandom % 12);
      if (r == 0) begin
        do_reset();
        idle(1);
      end else if (r == 1) begin
        idle(L);
      end else if ((mode == M_ARMED) && ($urandom % 2 == 0)) begin
        press(pw);
      end else begin
        press(CW'($urandom));
      end
    end

    idle(L + 4);
    chk("queue_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/safe_lockout_ctrl.md
# safe_lockout_ctrl

Sequencing controller for the safe-unlock datapath. It owns the password register, the attempt register, the equality comparator and a failed-attempt counter, and drives them from the ENTER button. After MAX_FAILS consecutive wrong attempts it forces a timed lockout during which ENTER is ignored. It replaces ad-hoc strobing of savePW/saveAT with a single controller that enforces attempt limits.

## Interface
Parameters:
- CODE_W, 4: width of code switches, password and attempt registers (≥1).
- MAX_FAILS, 3: consecutive mismatches that trigger lockout (≥1).
- LOCKOUT_CYCLES, 50_000_000: cycles spent in lockout (≥1).

Ports:
- clk  in  1  sole clock; all state updates on its rising edge.
- RESET  in  1  synchronous, active-high reset.
- ENTER  in  1  button level, already synchronized and debounced; 1 = pressed.
- CODE  in  CODE_W  code switches.
- LOCKED  out  1  1 = safe locked.
- ALARM  out  1  1 while in lockout.
- fail_count  out  $clog2(MAX_FAILS+1)  consecutive failed attempts.
- present_state_bits  out  3  current state encoding.

## Operation
- States and encodings: S_OPEN 000, S_SETPW 001, S_ARMED 010, S_TRY 011, S_EVAL 100, S_UNLOCK 101, S_LOCKOUT 110. Encoding 111 is illegal; it goes to S_OPEN on the next edge.
- S_OPEN: unlocked, with no password set. ENTER=1 → S_SETPW.
- S_SETPW: pw_reg <= CODE on every edge spent in this state. ENTER=0 → S_ARMED.
- S_ARMED: locked. ENTER=1 → S_TRY.
- S_TRY: at_reg <= CODE on every edge spent in this state. ENTER=0 → S_EVAL.
- S_EVAL: single cycle with ENTER ignored. Compare at_reg == pw_reg:
  - match → S_UNLOCK, fail_count <= 0.
  - mismatch with fail_count+1 < MAX_FAILS → S_ARMED, fail_count++.
  - mismatch with fail_count+1 == MAX_FAILS → S_LOCKOUT, fail_count <= MAX_FAILS, timer <= LOCKOUT_CYCLES-1.
- S_UNLOCK: unlocked. ENTER=1 → S_SETPW, so a new password is captured and the safe relocks on release.
- S_LOCKOUT: ENTER ignored. timer != 0 → timer--. timer == 0 → S_ARMED, fail_count <= 0. The password is retained.
- Outputs are Moore, decoded from the state register only:
  - LOCKED=1 in S_ARMED, S_TRY, S_EVAL and S_LOCKOUT; 0 otherwise.
  - ALARM=1 only in S_LOCKOUT.
- Reset values: state S_OPEN, pw_reg 0, at_reg 0, fail_count 0, timer 0. Hence LOCKED=0, ALARM=0, present_state_bits=000.
- Widths: timer is $clog2(LOCKOUT_CYCLES+1) bits. fail_count never exceeds MAX_FAILS.

## Timing
- A one-cycle ENTER pulse is a complete press and release.
- The captured password or attempt is the value of CODE at the edge that leaves S_SETPW or S_TRY, i.e. the edge that samples ENTER=0.
- Unlock latency: at edge k the release is sampled in S_TRY and the state becomes S_EVAL. At edge k+1 the state becomes S_UNLOCK and LOCKED falls.
- Lock latency: LOCKED rises after the edge that samples the release in S_SETPW.
- Lockout occupies exactly LOCKOUT_CYCLES cycles. ALARM rises after edge k+1 and falls after edge k+1+LOCKOUT_CYCLES.
- ENTER held through the lockout exit: the state goes S_ARMED → S_TRY on the next edge. This is a valid new attempt.
- RESET overrides every state, including S_LOCKOUT and S_EVAL. The design reaches reset values at the edge where RESET=1 is sampled.

## Structure
- Package safe_pkg holds:
  - typedef enum logic [2:0] state_t with the seven encodings above;
  - default parameter constants CODE_W_DEF, MAX_FAILS_DEF, LOCKOUT_CYCLES_DEF.
- One sub-module, lockout_timer: a parameterized down-counter with load and done outputs, instantiated once.
- The FSM, registers and comparator stay in safe_lockout_ctrl.

## Test plan
All scenarios use CODE_W=4, MAX_FAILS=3, LOCKOUT_CYCLES=8.
- Reset, then a one-cycle ENTER with CODE=4'hA → S_SETPW then S_ARMED; LOCKED=1 after the release edge; state bits 001 → 010.
- Attempt with CODE=4'hA → S_TRY, S_EVAL, S_UNLOCK; LOCKED=0 exactly two edges after the release; fail_count=0.
- Attempts 4'h3, then 4'h5, then 4'hA → fail_count goes 1, 2, then 0; third attempt unlocks; ALARM stays 0.
- Attempts 4'h1, 4'h2, 4'h3 → S_LOCKOUT with ALARM=1 for exactly 8 cycles and fail_count=3. ENTER pulses during lockout leave the state unchanged. Then S_ARMED, fail_count=0, and 4'hA still unlocks.
- In S_UNLOCK, ENTER with CODE=4'h6 → relocks; 4'hA now fails (fail_count=1); 4'h6 unlocks.
- RESET=1 for one cycle at lockout cycle 4 → next edge gives state 000, LOCKED=0, ALARM=0, fail_count=0. A fresh attempt sequence from S_OPEN first sets a new password.
